// File: rtl/mips_hazard_ctrl.sv
// Interlock and sequencing controller for a 5-stage MIPS32 pipeline: RAW stall/bubble
// insertion, taken-branch squash, and HLT drain into a sticky HALTED state.
module mips_hazard_ctrl #(
  parameter int HAZ_DEPTH = 3,
  parameter int NREG_W    = 5
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_ir,
  input  logic        branch_taken,
  output logic        stall,
  output logic        bubble_id_ex,
  output logic        kill_ex_mem,
  output logic        fetch_en,
  output logic        halted
);

  localparam int NSLOT = 3;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic              v;
    logic [NREG_W-1:0] dst;
  } slot_t;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  slot_t             slot_q [NSLOT];
  slot_t             slot_d [NSLOT];

  logic [5:0]        opcode;
  logic [NREG_W-1:0] rs, rt, rd, dst;
  logic              rs_use, rt_use, dst_use, is_hlt;
  logic              rs_chk, rt_chk, dst_chk;
  logic              src_hit, hazard, issue;
  logic              unused_imm;

  assign opcode     = id_ir[31:26];
  assign rs         = NREG_W'(id_ir[25:21]);
  assign rt         = NREG_W'(id_ir[20:16]);
  assign rd         = NREG_W'(id_ir[15:11]);
  assign unused_imm = ^id_ir[10:0];

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rs_use  = 1'b0;
    rt_use  = 1'b0;
    dst_use = 1'b0;
    dst     = rd;
    is_hlt  = 1'b0;
    case (opcode) inside
      [6'b000000:6'b000101]: begin
        dst_use = 1'b1;
        rs_use  = 1'b1;
        rt_use  = 1'b1;
      end
      6'b001000, [6'b001010:6'b001100]: begin
        dst     = rt;
        dst_use = 1'b1;
        rs_use  = 1'b1;
      end
      6'b001001: begin
        rs_use = 1'b1;
        rt_use = 1'b1;
      end
      6'b001101, 6'b001110: rs_use = 1'b1;
      6'b111111:            is_hlt = 1'b1;
      default: ;
    endcase
  end

  // R0 is hard-wired zero: it never produces or consumes a dependency.
  assign rs_chk  = rs_use  && (rs  != '0);
  assign rt_chk  = rt_use  && (rt  != '0);
  assign dst_chk = dst_use && (dst != '0);

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if ((i < HAZ_DEPTH) && slot_q[i].v &&
          ((rs_chk && (rs == slot_q[i].dst)) || (rt_chk && (rt == slot_q[i].dst))))
        src_hit = 1'b1;
    end
  end

  assign hazard = id_valid & src_hit;

  // Output logic: flush beats stall, and nothing issues outside RUN.
  always_comb begin
    stall        = hazard & ~branch_taken & (state_q == S_RUN);
    bubble_id_ex = stall | branch_taken | (state_q != S_RUN);
    kill_ex_mem  = branch_taken;
    fetch_en     = (state_q == S_RUN) & ~stall;
    halted       = (state_q == S_HALT);
  end

  assign issue = id_valid & ~bubble_id_ex;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RUN: begin
        if (issue && is_hlt) begin
          state_d = S_DRAIN;
          cnt_d   = 2'd3;
        end
      end
      S_DRAIN: begin
        if (branch_taken)        state_d = S_RUN;
        else if (cnt_q == 2'd0)  state_d = S_HALT;
        else                     cnt_d   = cnt_q - 2'd1;
      end
      S_HALT:  ;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    slot_d[0].v   = issue & dst_chk;
    slot_d[0].dst = dst;
    slot_d[1].v   = slot_q[0].v & ~kill_ex_mem;
    slot_d[1].dst = slot_q[0].dst;
    slot_d[2]     = slot_q[1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // NOTE: the tracker slots are control state, not storage, so reset must clear them or stale writers would stall.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= slot_d[i];
    end
  end

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboarded bench for mips_hazard_ctrl: depth-3 and depth-2 instances share stimulus;
// expected output vectors {stall,bubble,kill,fetch,halted} are queued per driven cycle.
module tb_mips_hazard_ctrl;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_ir;
  logic        branch_taken;

  logic stall3, bubble3, kill3, fetch3, halted3;
  logic stall2, bubble2, kill2, fetch2, halted2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [4:0] e3;
    logic       c2;
    logic [4:0] e2;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [4:0] RUN_OK  = 5'b00010;
  localparam logic [4:0] STALLED = 5'b11000;
  localparam logic [4:0] FLUSH   = 5'b01110;
  localparam logic [4:0] DRAIN   = 5'b01000;
  localparam logic [4:0] DR_BR   = 5'b01100;
  localparam logic [4:0] HALTED  = 5'b01001;

  mips_hazard_ctrl #(.HAZ_DEPTH(3), .NREG_W(5)) u_dut3 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_ir(id_ir),
    .branch_taken(branch_taken), .stall(stall3), .bubble_id_ex(bubble3),
    .kill_ex_mem(kill3), .fetch_en(fetch3), .halted(halted3)
  );

  mips_hazard_ctrl #(.HAZ_DEPTH(2), .NREG_W(5)) u_dut2 (
    .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_ir(id_ir),
    .branch_taken(branch_taken), .stall(stall2), .bubble_id_ex(bubble2),
    .kill_ex_mem(kill2), .fetch_en(fetch2), .halted(halted2)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [31:0] enc_rr(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_ri(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_LW  = 6'b001000, OP_SW  = 6'b001001, OP_BEQZ = 6'b001110;
  localparam logic [31:0] HLT_W = {6'b111111, 26'd0};

  // Drive one pipeline cycle at the falling edge and queue what the outputs must be.
  task automatic cyc(input logic v, input logic [31:0] ir, input logic bt, input logic [4:0] e3,
                     input string tag, input logic c2 = 1'b0, input logic [4:0] e2 = 5'b0);
    @(negedge clk1);
    id_valid     = v;
    id_ir        = ir;
    branch_taken = bt;
    sb_q.push_back('{tag, e3, c2, e2});
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n = 1'b0; id_valid = 1'b0; id_ir = '0; branch_taken = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] a3, a2;
    forever begin
      @(negedge clk1);
      #1;
      if (sb_q.size() > 0) begin
        e  = sb_q.pop_front();
        a3 = {stall3, bubble3, kill3, fetch3, halted3};
        a2 = {stall2, bubble2, kill2, fetch2, halted2};
        checks++;
        if (a3 !== e.e3) begin
          errors++;
          $display("FAIL %s depth3 {stall,bubble,kill,fetch,halted} got %b expected %b", e.tag, a3, e.e3);
        end
        if (e.c2) begin
          checks++;
          if (a2 !== e.e2) begin
            errors++;
            $display("FAIL %s depth2 {stall,bubble,kill,fetch,halted} got %b expected %b", e.tag, a2, e.e2);
          end
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    cyc(1'b0, '0, 1'b0, RUN_OK, "reset_idle", 1'b1, RUN_OK);
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 3), 1'b0, RUN_OK, "reset_no_hazard", 1'b1, RUN_OK);
  endtask

  task automatic test_raw_depth();
    do_reset();
    cyc(1'b1, enc_ri(OP_ADDI, 0, 1, 10), 1'b0, RUN_OK,  "raw_addi",   1'b1, RUN_OK);
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, STALLED, "raw_stall1", 1'b1, STALLED);
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, STALLED, "raw_stall2", 1'b1, STALLED);
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, STALLED, "raw_stall3", 1'b1, RUN_OK);
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, RUN_OK,  "raw_issue",  1'b1, RUN_OK);
    cyc(1'b0, '0, 1'b0, RUN_OK, "raw_idle");
  endtask

  task automatic test_raw_gap();
    do_reset();
    cyc(1'b1, enc_ri(OP_ADDI, 0, 1, 10), 1'b0, RUN_OK,  "gap_addi");
    cyc(1'b1, enc_rr(OP_ADD, 2, 3, 7),   1'b0, RUN_OK,  "gap_indep");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, STALLED, "gap_stall1");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, STALLED, "gap_stall2");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, RUN_OK,  "gap_issue");
  endtask

  task automatic test_r0_and_rt();
    do_reset();
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 0), 1'b0, RUN_OK,  "r0_dst");
    cyc(1'b1, enc_rr(OP_ADD, 0, 3, 5), 1'b0, RUN_OK,  "r0_src");
    cyc(1'b1, enc_ri(OP_BEQZ, 5, 0, 4), 1'b0, STALLED, "beqz_rs");
    cyc(1'b0, '0, 1'b0, RUN_OK, "r0_idle");
    do_reset();
    cyc(1'b1, enc_ri(OP_LW, 2, 1, 0), 1'b0, RUN_OK,  "lw_issue");
    cyc(1'b1, enc_ri(OP_SW, 3, 1, 0), 1'b0, STALLED, "sw_rt_stall1");
    cyc(1'b1, enc_ri(OP_SW, 3, 1, 0), 1'b0, STALLED, "sw_rt_stall2");
    cyc(1'b1, enc_ri(OP_SW, 3, 1, 0), 1'b0, STALLED, "sw_rt_stall3");
    cyc(1'b1, enc_ri(OP_SW, 3, 1, 0), 1'b0, RUN_OK,  "sw_issue");
  endtask

  task automatic test_branch_flush();
    do_reset();
    cyc(1'b1, enc_ri(OP_ADDI, 0, 1, 10), 1'b0, RUN_OK,  "br_addi");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b0, STALLED, "br_stalled");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b1, FLUSH,   "br_flush_over_stall");
    do_reset();
    cyc(1'b1, enc_ri(OP_ADDI, 0, 1, 10), 1'b0, RUN_OK, "kill_addi");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4),   1'b1, FLUSH,  "kill_pulse");
    cyc(1'b1, enc_rr(OP_SUB, 1, 2, 6),   1'b0, RUN_OK, "kill_mem_cleared");
  endtask

  task automatic test_halt();
    do_reset();
    cyc(1'b1, enc_rr(OP_ADD, 4, 3, 5), 1'b0, RUN_OK, "hlt_prev_add");
    cyc(1'b1, HLT_W, 1'b0, RUN_OK, "hlt_issue");
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, DRAIN, $sformatf("hlt_drain%0d", i));
    cyc(1'b0, '0, 1'b0, HALTED, "hlt_halted");
    cyc(1'b1, enc_rr(OP_ADD, 5, 5, 6), 1'b0, HALTED, "hlt_sticky_hazard");
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 3), 1'b0, HALTED, "hlt_sticky");
  endtask

  task automatic test_drain_branch();
    do_reset();
    cyc(1'b1, HLT_W, 1'b0, RUN_OK, "drbr_hlt");
    cyc(1'b0, '0,    1'b0, DRAIN,  "drbr_drain");
    cyc(1'b0, '0,    1'b1, DR_BR,  "drbr_branch");
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, RUN_OK, $sformatf("drbr_run%0d", i));
    do_reset();
    cyc(1'b1, HLT_W, 1'b1, FLUSH,  "hlt_with_branch");
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, RUN_OK, $sformatf("hlt_squashed%0d", i));
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    cyc(1'b1, enc_ri(OP_ADDI, 0, 1, 10), 1'b0, RUN_OK, "rstd_addi");
    cyc(1'b1, HLT_W, 1'b0, RUN_OK, "rstd_hlt");
    cyc(1'b0, '0, 1'b0, DRAIN, "rstd_drain");
    rst_n = 1'b0;
    cyc(1'b1, enc_rr(OP_ADD, 1, 2, 4), 1'b0, RUN_OK, "rstd_run_empty");
    rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, RUN_OK, "rstd_idle");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    rst_n = 1'b0; id_valid = 1'b0; id_ir = '0; branch_taken = 1'b0;
    test_reset();
    test_raw_depth();
    test_raw_gap();
    test_r0_and_rt();
    test_branch_flush();
    test_halt();
    test_drain_branch();
    test_reset_in_drain();
    repeat (2) @(negedge clk1);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
